pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the pipelined MIPS core. Replaces the fixed-field stage latches with one generic valid/ready stage.
- Carries an opaque DATA_W-bit payload: the bundled instruction, PC+4, operands, immediate and register indices.
- Adds backpressure with a 2-entry skid buffer (registered in_ready), valid tracking and flush/bubble insertion.
- Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB); hazard logic drives flush and downstream ready.

Parameters:
- DATA_W, 32, payload width in bits (1..1024).
- BUBBLE_VAL, 0, payload value presented whenever out_valid=0 (nop encoding); width DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous kill of all held and incoming words.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept; registered, equals ~skid_valid.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream word valid; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload; equals BUBBLE_VAL when out_valid=0.
- occupancy  output  2  number of held words, 0..2.

Behaviour:
- Reset (clk edge with reset=1): main_valid=0, skid_valid=0, main_data=skid_data=BUBBLE_VAL. Outputs after reset: out_valid=0, in_ready=1, out_data=BUBBLE_VAL, occupancy=0.
- Transfers: acc = in_valid & in_ready; dep = out_valid & out_ready. Both are evaluated on the same edge.
- Latency: one cycle in_data to out_data when the stage is empty or draining. Throughput is one word per cycle while out_ready=1.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY: acc -> ONE (main<=in_data). Otherwise stay in EMPTY.
  - ONE: acc&dep -> ONE (main<=in_data). acc&!dep -> TWO (skid<=in_data). !acc&dep -> EMPTY (main<=BUBBLE_VAL). Neither -> hold.
  - TWO: in_ready=0, so acc is impossible. dep -> ONE (main<=skid, skid<=BUBBLE_VAL). !dep -> hold.
- Order is preserved: the skid word always leaves after the main word.
- flush=1 at an edge:
  - Next state is EMPTY and all data goes to BUBBLE_VAL.
  - A word accepted on that same edge (acc=1) is discarded.
  - A word departing on that edge (dep=1) counts as delivered downstream.
- Priority: reset > flush > normal operation.
- in_ready depends only on registered state, never combinationally on out_ready.
- No output changes between edges, except out_data following main_data.
- Stall: holding out_ready=0 for any number of cycles loses no data. At most 2 words are held.
- Reset or flush asserted mid-stall clears everything with no partial state.
- X on in_data while in_valid=0 must not propagate to out_data.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, add two output ports:
  - stall_cnt (32 bits): increments each cycle with out_valid & !out_ready.
  - flush_cnt (16 bits): increments each flush edge that discards at least one valid word, held or incoming.
  - Both counters clear on reset, saturate at their maximum and are unaffected by flush clearing data.
- When undefined, these ports and their registers do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding constants (ST_EMPTY, ST_ONE, ST_TWO);
  - the default nop payload constant;
  - per-stage DATA_W constants and field offset constants for the IF/ID, ID/EX, EX/MEM and MEM/WB bundles.
- One sub-module: pipe_sat_counter (parametrised width, enable, sync clear, saturating), instantiated twice under PIPE_STAGE_PERF_EN.
- The data path stays in the top module.

Test Plan:
- Reset then idle: after reset, out_valid=0, in_ready=1, out_data=0, occupancy=0.
- Streaming, DATA_W=32, out_ready=1: drive in_data 0x1,0x2,0x3 on consecutive cycles. out_data shows 0x1,0x2,0x3 one cycle later each, with no bubbles.
- Backpressure:
  - Send 0xA then 0xB while out_ready=0. occupancy goes 1 then 2, and in_ready=0 after the second accept.
  - Raise out_ready. Delivered order is 0xA then 0xB, and in_ready returns to 1 after the first departure.
- Flush at occupancy=2 with in_valid=1 and in_data=0xC:
  - Next cycle: occupancy=0, out_valid=0, out_data=BUBBLE_VAL; 0xC is never seen.
  - With PIPE_STAGE_PERF_EN, flush_cnt=1.
- Simultaneous accept and depart in state ONE (main=0x5, in_data=0x6, out_ready=1): next cycle out_data=0x6, occupancy=1.
- PERF counters: hold out_valid=1 with out_ready=0 for 10 cycles, then assert reset. stall_cnt reads 10, then 0 after reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding, nop payload
// and per-stage payload layouts.
package pipe_pkg;

   // Encoding is {skid_valid, main_valid}.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b11
   } pipe_state_e;

   // sll $0,$0,0 encodes as all zeros.
   localparam logic [31:0] NOP_PAYLOAD = 32'h0000_0000;

   localparam int unsigned IFID_INSTR_OFS = 0;
   localparam int unsigned IFID_PC4_OFS   = 32;
   localparam int unsigned IFID_W         = 64;

   localparam int unsigned IDEX_PC4_OFS    = 0;
   localparam int unsigned IDEX_RS_VAL_OFS = 32;
   localparam int unsigned IDEX_RT_VAL_OFS = 64;
   localparam int unsigned IDEX_IMM_OFS    = 96;
   localparam int unsigned IDEX_RS_OFS     = 128;
   localparam int unsigned IDEX_RT_OFS     = 133;
   localparam int unsigned IDEX_RD_OFS     = 138;
   localparam int unsigned IDEX_W          = 143;

   localparam int unsigned EXMEM_ALU_OFS   = 0;
   localparam int unsigned EXMEM_STORE_OFS = 32;
   localparam int unsigned EXMEM_DEST_OFS  = 64;
   localparam int unsigned EXMEM_W         = 69;

   localparam int unsigned MEMWB_RESULT_OFS = 0;
   localparam int unsigned MEMWB_DEST_OFS   = 32;
   localparam int unsigned MEMWB_W          = 37;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module pipe_sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer and flush.
// Optional perf counters (stall_cnt_o, flush_cnt_o) under PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_PAYLOAD)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [15:0]       flush_cnt_o
`endif
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready, out_valid;
   logic              acc, dep;

   assign acc = in_valid_i & in_ready;
   assign dep = out_valid & out_ready_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Vacated slots are refilled with BUBBLE_VAL so out_data needs no mux.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d = ST_ONE;
                  main_d  = in_data_i;
               end
            end
            ST_ONE: begin
               if (acc && dep) begin
                  main_d = in_data_i;
               end else if (acc) begin
                  state_d = ST_TWO;
                  skid_d  = in_data_i;
               end else if (dep) begin
                  state_d = ST_EMPTY;
                  main_d  = BUBBLE_VAL;
               end
            end
            ST_TWO: begin
               if (dep) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   always_comb begin
      in_ready    = 1'b1;
      out_valid   = 1'b0;
      occupancy_o = 2'd0;
      unique case (state_q)
         ST_EMPTY: begin
         end
         ST_ONE: begin
            out_valid   = 1'b1;
            occupancy_o = 2'd1;
         end
         ST_TWO: begin
            in_ready    = 1'b0;
            out_valid   = 1'b1;
            occupancy_o = 2'd2;
         end
         default: begin
         end
      endcase
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = out_valid;
   assign out_data_o  = main_q;

`ifdef PIPE_STAGE_PERF_EN
   logic stall_en, discard;

   assign stall_en = out_valid & ~out_ready_i;
   // A main word leaving on the flush edge is delivered, not discarded.
   assign discard  = flush_i & (acc | (state_q == ST_TWO) | ((state_q == ST_ONE) & ~dep));

   pipe_sat_counter #(
      .WIDTH(32)
   ) u_stall_cnt (
      .clk  (clk),
      .clr_i(reset),
      .en_i (stall_en),
      .cnt_o(stall_cnt_o)
   );

   pipe_sat_counter #(
      .WIDTH(16)
   ) u_flush_cnt (
      .clk  (clk),
      .clr_i(reset),
      .en_i (discard),
      .cnt_o(flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_reg;

   localparam int unsigned DATA_W = 32;
   localparam logic [DATA_W-1:0] BUBBLE = '0;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, out_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]       stall_cnt;
   logic [15:0]       flush_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] mq[$];
   longint unsigned   m_stall, m_flush;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W    (DATA_W),
      .BUBBLE_VAL(BUBBLE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .occupancy_o(occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt_o(stall_cnt),
      .flush_cnt_o(flush_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic compare_model();
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("out_data", 64'(out_data), 64'((mq.size() > 0) ? mq[0] : BUBBLE));
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
   endtask

   // Advance one edge: update the model from the pre-edge inputs, then compare.
   task automatic step();
      bit acc, dep;
      acc = in_valid && (mq.size() < 2);
      dep = (mq.size() > 0) && out_ready;
      if (reset) begin
         mq.delete();
         m_stall = 0;
         m_flush = 0;
      end else begin
         if ((mq.size() > 0) && !out_ready && (m_stall < 64'hFFFF_FFFF)) m_stall++;
         if (flush) begin
            if ((acc || (mq.size() > 1) || ((mq.size() == 1) && !dep)) && (m_flush < 64'hFFFF))
               m_flush++;
            mq.delete();
         end else begin
            if (dep) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      m_stall = 0;
      m_flush = 0;
      step();
      step();
      reset = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);

      // Streaming with no backpressure
      drive(1'b1, 32'h1, 1'b1, 1'b0);
      step();
      check("stream_1", 64'(out_data), 64'h1);
      drive(1'b1, 32'h2, 1'b1, 1'b0);
      step();
      check("stream_2", 64'(out_data), 64'h2);
      drive(1'b1, 32'h3, 1'b1, 1'b0);
      step();
      check("stream_3", 64'(out_data), 64'h3);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check("stream_drain", 64'(occupancy), 64'd0);

      // Backpressure: fill both slots, then drain in order
      drive(1'b1, 32'hA, 1'b0, 1'b0);
      step();
      check("bp_occ1", 64'(occupancy), 64'd1);
      drive(1'b1, 32'hB, 1'b0, 1'b0);
      step();
      check("bp_occ2", 64'(occupancy), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_first", 64'(out_data), 64'hA);
      step();
      check("bp_second", 64'(out_data), 64'hB);
      check("bp_ready_back", 64'(in_ready), 64'd1);
      step();

      // Flush at occupancy 2 with an incoming word
      drive(1'b1, 32'h11, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h12, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hC, 1'b0, 1'b1);
      step();
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_data", 64'(out_data), 64'(BUBBLE));
`ifdef PIPE_STAGE_PERF_EN
      check("flush_cnt_1", 64'(flush_cnt), 64'd1);
`endif
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check("flush_no_c", 64'(out_valid), 64'd0);

      // Simultaneous accept and depart in ONE
      drive(1'b1, 32'h5, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'h6, 1'b1, 1'b0);
      step();
      check("accdep_data", 64'(out_data), 64'h6);
      check("accdep_occ", 64'(occupancy), 64'd1);

      // Stall counter: 10 stalled edges, then reset
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      drive(1'b1, 32'h77, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step();
`ifdef PIPE_STAGE_PERF_EN
      check("stall_10", 64'(stall_cnt), 64'd10);
`endif
      check("stall_held", 64'(out_data), 64'h77);
      reset = 1'b1;
      step();
      reset = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
      check("stall_rst", 64'(stall_cnt), 64'd0);
`endif
      check("stall_rst_occ", 64'(occupancy), 64'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         drive($urandom_range(0, 2) != 0, $urandom(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
